store_to_fetch_queue: RTL
=========================

Name: store_to_fetch_queue

Overview:
- Parametrised successor to the single-slot store-to-fetch bus.
- Carries StoreToFetchPacket-class payloads (PC redirects, store-completion notices) from the store stage back to fetch.
- Buffers up to DEPTH packets with valid/ready handshakes on both sides, which replaces the old "assert not full / assert full" contract.
- Adds flush, occupancy reporting and sticky protocol-error flags.

Parameters:
- DATA_WIDTH, 64: payload width in bits (packet packed to a vector).
- DEPTH, 4: number of entries; power of two, at least 2.
- CNT_WIDTH, $clog2(DEPTH)+1: width of the occupancy counter. Derived; do not override.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset_n  in  1  Reset, asynchronous and active-low (already decided). Asserting it clears all state immediately.
- send_valid  in  1  Store stage presents a packet.
- send_data  in  DATA_WIDTH  Packet payload.
- send_ready  out  1  Queue can accept; equals !full. Registered-derived, with no combinational path from recv_ready.
- recv_valid  out  1  Head entry is valid; equals !empty.
- recv_data  out  DATA_WIDTH  Head entry payload; driven from storage, not from send_data.
- recv_ready  in  1  Fetch consumes the head entry this cycle.
- flush  in  1  Discards all entries (pipeline redirect).
- count  out  CNT_WIDTH  Current occupancy, 0..DEPTH.
- err_overflow  out  1  Sticky: send_valid was high while send_ready was low.
- err_underflow  out  1  Sticky: recv_ready was high while recv_valid was low.
- err_clear  in  1  Clears both sticky error flags.

Behaviour:
- Reset values while reset_n is low: rd_ptr=0, wr_ptr=0, count=0, send_ready=1, recv_valid=0, recv_data=0, err_overflow=0, err_underflow=0. Storage contents are don't-care.
- Push: send_valid && send_ready → write send_data at wr_ptr, advance wr_ptr mod DEPTH.
- Pop: recv_valid && recv_ready → advance rd_ptr mod DEPTH.
- Latency: a packet pushed in cycle N is visible on recv_valid/recv_data in cycle N+1. There is no same-cycle bypass.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Full (count==DEPTH): send_ready=0 even if a pop occurs in the same cycle. Push while full is dropped and sets err_overflow.
- Empty (count==0): recv_valid=0. recv_data holds the last-written slot at rd_ptr and is don't-care for the consumer. recv_ready while empty sets err_underflow.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decoded from count, not from pointer equality.
- Flush: takes priority over push and pop in the same cycle. The next state is rd_ptr=wr_ptr=0, count=0, and any concurrent push is discarded.
  - A concurrent push during flush is NOT an overflow error.
  - A concurrent recv_ready during flush is evaluated against the pre-flush state, so it is an underflow error only if the queue was already empty.
- Error flags: set on the cycle after the violating condition and held until err_clear or reset.
  - If err_clear and a new violation occur in the same cycle, set wins.
- Reset mid-operation: asynchronous clear at any point. After reset_n deasserts, the first push is accepted on the first rising edge.
- State machine (per-entry status is implied by count): EMPTY (count=0) → PARTIAL (0<count<DEPTH) → FULL (count=DEPTH). Any state → EMPTY on flush.
- Assertions for the bench:
  - count never exceeds DEPTH.
  - recv_valid equals (count!=0).
  - send_ready equals (count!=DEPTH).

Decomposition:
- Shared package (ecc_bus_pkg):
  - the StoreToFetchPacket typedef and its packed width constant STF_PKT_WIDTH (default for DATA_WIDTH);
  - the shared enum for EMPTY/PARTIAL/FULL status, used by the bench for coverage.
- One sub-module, bus_fifo_storage: DEPTH×DATA_WIDTH register array with one write port and one asynchronous read port. The top level holds the pointers, counter, flags and handshake logic.

Test Plan:
- Single packet: push 0xDEADBEEF in cycle 1 → recv_valid=1 with recv_data=0xDEADBEEF in cycle 2, count=1. Pop in cycle 2 → count=0 and recv_valid=0 in cycle 3.
- Fill and overflow (DEPTH=4): push 0x1..0x4 → send_ready=0, count=4. Push 0x5 → dropped, err_overflow=1. Pops return exactly 0x1,0x2,0x3,0x4.
- Wrap-around: 10 push/pop pairs with one entry kept resident (values 0x10..0x19) → FIFO order preserved, count stays at 1, pointers wrap twice.
- Simultaneous push+pop with count=2 → count stays 2, head advances, new tail is written correctly. Same attempt at count=4 → push refused, pop completes, count=3.
- Flush with a concurrent push at count=3 → next cycle count=0, recv_valid=0, no err_overflow. The following push of 0xA5 appears at the head.
- Underflow and clear: recv_ready while empty → err_underflow=1, held for 5 cycles. err_clear → 0. reset_n low mid-fill (count=2) → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ecc_bus_pkg.sv
// Shared types for the store-to-fetch return path.
//   store_to_fetch_packet_t : packet carried from the store stage back to fetch
//   STF_PKT_WIDTH           : packed width of that packet (default queue payload width)
//   queue_status_t          : EMPTY / PARTIAL / FULL occupancy class
//   queue_status()          : maps an occupancy count onto queue_status_t
package ecc_bus_pkg;

  typedef struct packed {
    logic [1:0]  kind;  // redirect or store-completion notice
    logic [5:0]  tag;   // store id or redirect cause
    logic [55:0] pc;    // redirect target / store pc
  } store_to_fetch_packet_t;

  localparam int unsigned STF_PKT_WIDTH = $bits(store_to_fetch_packet_t);

  localparam logic [1:0] PKT_KIND_REDIRECT   = 2'd1;
  localparam logic [1:0] PKT_KIND_STORE_DONE = 2'd2;

  typedef enum logic [1:0] {
    QueueEmpty,
    QueuePartial,
    QueueFull
  } queue_status_t;

  function automatic queue_status_t queue_status(input int unsigned occ,
                                                 input int unsigned depth);
    if (occ == 0) return QueueEmpty;
    if (occ >= depth) return QueueFull;
    return QueuePartial;
  endfunction

endpackage

// File: rtl/bus_fifo_storage.sv
// Register array backing the store-to-fetch queue.
//   clk, reset_n : clock, asynchronous active-low reset (clears every entry)
//   wr_en        : write wr_data into entry wr_addr on the rising edge
//   wr_addr      : write index
//   wr_data      : write payload
//   rd_addr      : read index
//   rd_data      : asynchronous read of entry rd_addr
module bus_fifo_storage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Entries are cleared on reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/store_to_fetch_queue.sv
// DEPTH-entry valid/ready queue carrying store-to-fetch packets back to fetch.
//   clk, reset_n  : clock, asynchronous active-low reset
//   send_valid    : store stage presents send_data
//   send_data     : packet payload
//   send_ready    : queue can accept (not full); depends only on registered state
//   recv_valid    : head entry valid (not empty)
//   recv_data     : head entry payload, read from storage
//   recv_ready    : fetch consumes the head entry
//   flush         : discard all entries; wins over push and pop
//   count         : occupancy, 0..DEPTH
//   err_overflow  : sticky, push attempted while full
//   err_underflow : sticky, pop attempted while empty
//   err_clear     : clears both sticky flags (a same-cycle violation wins)
module store_to_fetch_queue
  import ecc_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = STF_PKT_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  recv_valid,
  output logic [DATA_WIDTH-1:0] recv_data,
  input  logic                  recv_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clear
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_overflow_q, err_overflow_d;
  logic                 err_underflow_q, err_underflow_d;

  logic push, pop;
  logic overflow_event, underflow_event;

  // Full/empty come from the counter only, so pointer equality never has to be
  // disambiguated and send_ready has no path from recv_ready.
  assign send_ready = (count_q != FULL_COUNT);
  assign recv_valid = (count_q != '0);

  assign push = send_valid && send_ready && !flush;
  assign pop  = recv_valid && recv_ready && !flush;

  // A push racing a flush is simply discarded; underflow is judged on the
  // pre-flush occupancy.
  assign overflow_event  = send_valid && !send_ready && !flush;
  assign underflow_event = recv_ready && !recv_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    err_overflow_d  = overflow_event  | (err_overflow_q  & ~err_clear);
    err_underflow_d = underflow_event | (err_underflow_q & ~err_clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  bus_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_storage (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (send_data),
    .rd_addr (rd_ptr_q),
    .rd_data (recv_data)
  );

  assign count         = count_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule
